// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue ALU execute stage with an iterative multiplier.
//   Requests are accepted on in_valid & in_ready. At acceptance the unit captures
//   the operands and decodes {ALUop, fun7, fun3} into a 4-bit control code. Most
//   operations complete in one cycle. MUL is a shift-add sequence that runs for
//   XLEN cycles. The result is held until the consumer accepts it with out_ready.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   in_valid / in_ready   request handshake
//   ALUop, fun7, fun3     instruction class and function fields
//   op_a, op_b            operands (op_b is rs2 or the immediate)
//   out_valid / out_ready result handshake
//   result, zero          held result and its zero flag
//   ctrl_code, illegal    decoded control code of the held result; undecodable flag
module alu_exec_unit #(
  parameter int XLEN   = 32,
  parameter int MUL_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUop,
  input  logic [6:0]      fun7,
  input  logic [2:0]      fun3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      ctrl_code,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  typedef enum logic [3:0] {
    C_AND  = 4'b0000,
    C_OR   = 4'b0001,
    C_ADD  = 4'b0010,
    C_XOR  = 4'b0011,
    C_SLL  = 4'b0100,
    C_SRL  = 4'b0101,
    C_SUB  = 4'b0110,
    C_SRA  = 4'b0111,
    C_SLT  = 4'b1000,
    C_SLTU = 4'b1001,
    C_MUL  = 4'b1010,
    C_ILL  = 4'b1111
  } ctrl_e;

  state_e          state_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic [3:0]      ctrl_q;
  logic            illegal_q;
  logic [XLEN-1:0] mcand_q;   // multiplicand, shifts left each step
  logic [XLEN-1:0] mplier_q;  // multiplier, shifts right each step
  logic [XLEN-1:0] acc_q;
  logic [CW-1:0]   cnt_q;

  ctrl_e           dec;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] acc_nxt;
  logic [SW-1:0]   shamt;
  logic            accept;

  // Function map shared by register-register (fun7 = 0) and immediate forms.
  function automatic ctrl_e base_map(input logic [2:0] f3);
    ctrl_e c;
    unique case (f3)
      3'b000:  c = C_ADD;
      3'b001:  c = C_SLL;
      3'b010:  c = C_SLT;
      3'b011:  c = C_SLTU;
      3'b100:  c = C_XOR;
      3'b101:  c = C_SRL;
      3'b110:  c = C_OR;
      default: c = C_AND;
    endcase
    return c;
  endfunction

  always_comb begin
    dec = C_ILL;
    unique case (ALUop)
      2'b00: dec = C_ADD;
      2'b01: dec = C_SUB;
      2'b10: begin
        unique case (fun7)
          7'b0000000: dec = base_map(fun3);
          7'b0100000: begin
            if (fun3 == 3'b000)      dec = C_SUB;
            else if (fun3 == 3'b101) dec = C_SRA;
          end
          7'b0000001: begin
            if (fun3 == 3'b000 && MUL_EN != 0) dec = C_MUL;
          end
          default: dec = C_ILL;
        endcase
      end
      default: begin
        unique case (fun3)
          3'b001: dec = (fun7 == 7'b0000000) ? C_SLL : C_ILL;
          3'b101: begin
            if (fun7 == 7'b0000000)      dec = C_SRL;
            else if (fun7 == 7'b0100000) dec = C_SRA;
          end
          default: dec = base_map(fun3);
        endcase
      end
    endcase
  end

  assign shamt = op_b[SW-1:0];

  always_comb begin
    alu_res = '0;
    unique case (dec)
      C_AND:  alu_res = op_a & op_b;
      C_OR:   alu_res = op_a | op_b;
      C_ADD:  alu_res = op_a + op_b;
      C_XOR:  alu_res = op_a ^ op_b;
      C_SLL:  alu_res = op_a << shamt;
      C_SRL:  alu_res = op_a >> shamt;
      C_SUB:  alu_res = op_a - op_b;
      C_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      C_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      C_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default: alu_res = '0;
    endcase
  end

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign ctrl_code = ctrl_q;
  assign illegal   = illegal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          // A DONE handoff and a new acceptance share one edge so 1-cycle ops
          // stream back to back without an idle bubble.
          if (accept) begin
            ctrl_q    <= dec;
            illegal_q <= (dec == C_ILL);
            if (dec == C_MUL) begin
              state_q  <= BUSY;
              mcand_q  <= op_a;
              mplier_q <= op_b;
              acc_q    <= '0;
              cnt_q    <= '0;
            end else begin
              state_q  <= DONE;
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
            end
          end else if (state_q == DONE && out_ready) begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          // The last step folds straight into the result register.
          if (cnt_q == CNT_LAST) begin
            state_q  <= DONE;
            result_q <= acc_nxt;
            zero_q   <= (acc_nxt == '0);
            cnt_q    <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  ctrl;
    logic        ill;
    int          lat;
    int          acc;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  ALUop = '0;
  logic [6:0]  fun7 = '0;
  logic [2:0]  fun3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic [3:0]  ctrl_code;
  logic        illegal;

  // Second build with the multiplier disabled.
  logic        v0 = 1'b0;
  logic        rdy0;
  logic [1:0]  aop0 = '0;
  logic [6:0]  f70 = '0;
  logic [2:0]  f30 = '0;
  logic [31:0] a0 = '0;
  logic [31:0] b0 = '0;
  logic        ov0;
  logic [31:0] res0;
  logic        z0;
  logic [3:0]  cc0;
  logic        ill0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;
  item_t sb[$];
  int fmap[8] = '{2, 4, 8, 9, 3, 5, 1, 0};

  alu_exec_unit #(.XLEN(32), .MUL_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUop(ALUop), .fun7(fun7), .fun3(fun3), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .ctrl_code(ctrl_code), .illegal(illegal)
  );

  alu_exec_unit #(.XLEN(32), .MUL_EN(0)) dut_nomul (
    .clk(clk), .reset(reset), .in_valid(v0), .in_ready(rdy0),
    .ALUop(aop0), .fun7(f70), .fun3(f30), .op_a(a0), .op_b(b0),
    .out_valid(ov0), .out_ready(1'b1), .result(res0), .zero(z0),
    .ctrl_code(cc0), .illegal(ill0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected outcome straight from the decode table and
  // plain arithmetic.
  function automatic item_t model(input logic [1:0] op, input logic [6:0] f7,
                                  input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
    item_t e;
    int k;
    logic [63:0] p;
    longint sa;
    k = 15;
    if (op == 2'd0) k = 2;
    else if (op == 2'd1) k = 6;
    else if (op == 2'd2) begin
      if (f7 == 7'h00) k = fmap[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) k = 6;
      else if (f7 == 7'h20 && f3 == 3'd5) k = 7;
      else if (f7 == 7'h01 && f3 == 3'd0) k = 10;
    end else begin
      if (f3 == 3'd1) k = (f7 == 7'h00) ? 4 : 15;
      else if (f3 == 3'd5) k = (f7 == 7'h00) ? 5 : ((f7 == 7'h20) ? 7 : 15);
      else k = fmap[f3];
    end
    sa = longint'($signed(a));
    p = {32'd0, a} * {32'd0, b};
    case (k)
      0:  e.res = a & b;
      1:  e.res = a | b;
      2:  e.res = a + b;
      3:  e.res = a ^ b;
      4:  e.res = a << b[4:0];
      5:  e.res = a >> b[4:0];
      6:  e.res = a - b;
      7:  e.res = 32'(sa >>> b[4:0]);
      8:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9:  e.res = (a < b) ? 32'd1 : 32'd0;
      10: e.res = p[31:0];
      default: e.res = 32'd0;
    endcase
    e.ctrl = 4'(k);
    e.ill = (k == 15);
    e.lat = (k == 10) ? 33 : 1;
    e.acc = 0;
    return e;
  endfunction

  function automatic item_t mk(input logic [31:0] r, input logic [3:0] c,
                               input logic il, input int lat);
    item_t e;
    e.res = r; e.ctrl = c; e.ill = il; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // Issue one request; the expected response is queued at the acceptance edge.
  task automatic issue(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input item_t e);
    bit got = 1'b0;
    ALUop = op; fun7 = f7; fun3 = f3; op_a = a; op_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc = cyc;
        sb.push_back(e);
        got = 1'b1;
        break;
      end
    end
    chk("accept_timeout", 64'(got), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs after capture; the in-flight op must not notice.
    ALUop = 2'($urandom); fun7 = 7'($urandom); fun3 = 3'($urandom);
    op_a = $urandom; op_b = $urandom;
  endtask

  task automatic issue_rand();
    logic [1:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [31:0] a, b;
    op = ($urandom_range(0, 5) < 4) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
    case ($urandom_range(0, 4))
      0, 1: f7 = 7'h00;
      2: f7 = 7'h20;
      3: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    f3 = 3'($urandom);
    a = rand_val();
    b = rand_val();
    issue(op, f7, f3, a, b, model(op, f7, f3, a, b));
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares each presented result with the queue head, checks
  // latency on first presentation and stability while stalled.
  bit          held_v = 1'b0;
  logic [31:0] h_res;
  logic [3:0]  h_ctrl;
  logic        h_ill, h_zero;
  always @(negedge clk) begin
    if (reset) begin
      held_v = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        if (!held_v) begin
          chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          chk("result", 64'(result), 64'(sb[0].res));
          chk("ctrl_code", 64'(ctrl_code), 64'(sb[0].ctrl));
          chk("illegal", 64'(illegal), 64'(sb[0].ill));
          chk("zero", 64'(zero), 64'(sb[0].res == 32'd0));
        end else begin
          chk("hold_result", 64'(result), 64'(h_res));
          chk("hold_ctrl", 64'(ctrl_code), 64'(h_ctrl));
          chk("hold_illegal", 64'(illegal), 64'(h_ill));
          chk("hold_zero", 64'(zero), 64'(h_zero));
          chk("stall_in_ready", 64'(in_ready), 64'(out_ready));
        end
        h_res = result; h_ctrl = ctrl_code; h_ill = illegal; h_zero = zero;
        if (out_ready) begin
          void'(sb.pop_front());
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
        end
      end
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check_idle_state(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_zero"}, 64'(zero), 64'd1);
    chk({tag, "_ctrl"}, 64'(ctrl_code), 64'd0);
    chk({tag, "_illegal"}, 64'(illegal), 64'd0);
  endtask

  initial begin
    int n;
    cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check_idle_state("reset");
    chk("nomul_reset_in_ready", 64'(rdy0), 64'd1);
    chk("nomul_reset_out_valid", 64'(ov0), 64'd0);
    @(posedge clk); #1;

    // Multiplier-less build: MUL encoding completes next cycle as illegal.
    aop0 = 2'b10; f70 = 7'h01; f30 = 3'd0; a0 = 32'd6; b0 = 32'd7; v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(negedge clk);
    chk("nomul_out_valid", 64'(ov0), 64'd1);
    chk("nomul_illegal", 64'(ill0), 64'd1);
    chk("nomul_result", 64'(res0), 64'd0);
    chk("nomul_ctrl", 64'(cc0), 64'hF);
    @(posedge clk); #1;

    // Directed vectors with literal expectations.
    issue(2'b10, 7'h20, 3'd0, 32'd5, 32'd7, mk(32'hFFFF_FFFE, 4'b0110, 1'b0, 1));
    issue(2'b11, 7'h20, 3'd5, 32'h8000_0000, 32'h404, mk(32'hF800_0000, 4'b0111, 1'b0, 1));
    issue(2'b11, 7'h00, 3'd3, 32'd1, 32'hFFFF_FFFF, mk(32'd1, 4'b1001, 1'b0, 1));
    issue(2'b10, 7'h02, 3'd0, 32'd9, 32'd9, mk(32'd0, 4'b1111, 1'b1, 1));
    issue(2'b00, 7'h7F, 3'd7, 32'hFFFF_FFFF, 32'd1, mk(32'd0, 4'b0010, 1'b0, 1));

    // MUL: in_ready held low for the whole iteration.
    issue(2'b10, 7'h01, 3'd0, 32'hFFFF_FFFF, 32'd3, mk(32'hFFFF_FFFD, 4'b1010, 1'b0, 33));
    n = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (!in_ready) n++;
    end
    chk("mul_busy_cycles", 64'(n), 64'd32);
    cycles(3);

    // Backpressure then same-cycle handoff/accept.
    out_ready = 1'b0;
    issue(2'b00, 7'h00, 3'd0, 32'd2, 32'd3, mk(32'd5, 4'b0010, 1'b0, 1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_result", 64'(result), 64'd5);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(2'b10, 7'h00, 3'd0, 32'd10, 32'd20, mk(32'd30, 4'b0010, 1'b0, 1));
    cycles(2);

    // Reset during BUSY aborts the multiply.
    issue(2'b10, 7'h01, 3'd0, 32'd123, 32'd456, mk(32'd56088, 4'b1010, 1'b0, 33));
    cycles(9);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check_idle_state("abort");
    cycles(40);

    // Randomized phase with random consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      issue_rand();
      if ($urandom_range(0, 3) == 0) cycles(1);
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
